// File: rtl/display_source_arbiter_if.sv
// Purpose: groups the source-side inputs and display-side outputs of the display source arbiter.
// Latency: none, this is wiring only.
// Backpressure: none; notify_req is accepted in the cycle it is seen, and notify_ack confirms it.
interface display_source_arbiter_if;
  logic [31:0] bg_data;
  logic        edit_active;
  logic [31:0] edit_data;
  logic [7:0]  edit_blink_mask;
  logic        notify_req;
  logic [31:0] notify_data;
  logic        notify_ack;
  logic        notify_done;
  logic [31:0] disp_data;
  logic [1:0]  disp_src;
  logic        blink_phase;

  // Sources and the display consumer sit on the master side.
  modport master (
    output bg_data, edit_active, edit_data, edit_blink_mask, notify_req, notify_data,
    input  notify_ack, notify_done, disp_data, disp_src, blink_phase
  );

  // The arbiter sits on the slave side.
  modport slave (
    input  bg_data, edit_active, edit_data, edit_blink_mask, notify_req, notify_data,
    output notify_ack, notify_done, disp_data, disp_src, blink_phase
  );
endinterface

// File: rtl/display_source_arbiter.sv
// Purpose: picks the nibble bus shown on the 8-digit display (priority NOTIFY > EDIT > BG) and blinks edit digits.
// Latency: all outputs are registered; data passes through with 1 cycle of latency, and a source switch shows on the same edge.
// Backpressure: none; notify_req is taken every cycle it is high, and each acceptance reloads the on-screen hold.
module display_source_arbiter #(
  parameter int unsigned BLINK_HALF   = 125,
  parameter int unsigned NOTIFY_TICKS = 1000,
  parameter logic [3:0]  BLANK_NIBBLE = 4'hF
) (
  input logic                     clk_500hz,
  input logic                     rst,
  display_source_arbiter_if.slave bus
);

  localparam int unsigned HOLD_W  = $clog2(NOTIFY_TICKS);
  localparam int unsigned BLINK_W = $clog2(BLINK_HALF + 1);

  // Encoding doubles as the disp_src code.
  typedef enum logic [1:0] {
    ST_BG     = 2'b00,
    ST_EDIT   = 2'b01,
    ST_NOTIFY = 2'b10
  } state_t;

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [BLINK_W-1:0]  blink_cnt, blink_cnt_nxt;
  logic                blink_phase_q, blink_phase_nxt;
  logic [31:0]         notify_lat, notify_lat_nxt;
  logic [31:0]         disp_data_q, disp_data_nxt;
  logic [1:0]          disp_src_q;
  logic                notify_ack_q, ack_nxt;
  logic                notify_done_q, done_nxt;

  // Source selection: a request always wins; otherwise hold down a notification or follow edit_active.
  always_comb begin
    state_nxt      = state;
    hold_nxt       = hold_cnt;
    notify_lat_nxt = notify_lat;
    ack_nxt        = 1'b0;
    done_nxt       = 1'b0;
    if (bus.notify_req) begin
      // Accept or retrigger. This also swallows an expiry that falls on the same cycle.
      notify_lat_nxt = bus.notify_data;
      hold_nxt       = HOLD_W'(NOTIFY_TICKS - 1);
      ack_nxt        = 1'b1;
      state_nxt      = ST_NOTIFY;
    end else begin
      case (state)
        ST_NOTIFY: begin
          if (hold_cnt != '0) begin
            hold_nxt = hold_cnt - 1'b1;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = bus.edit_active ? ST_EDIT : ST_BG;
          end
        end
        ST_BG:   if (bus.edit_active)  state_nxt = ST_EDIT;
        ST_EDIT: if (!bus.edit_active) state_nxt = ST_BG;
        default: state_nxt = ST_BG;
      endcase
    end
  end

  // Blink timebase: free-running, restarted in the visible phase whenever EDIT is entered.
  always_comb begin
    blink_cnt_nxt   = blink_cnt + 1'b1;
    blink_phase_nxt = blink_phase_q;
    if (state_nxt == ST_EDIT && state != ST_EDIT) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_HALF - 1)) begin
      blink_cnt_nxt   = '0;
      blink_phase_nxt = ~blink_phase_q;
    end
  end

  // Display mux, driven from next-state values so a source switch appears on the switching edge.
  always_comb begin
    disp_data_nxt = bus.bg_data;
    case (state_nxt)
      ST_EDIT: begin
        for (int i = 0; i < 8; i++) begin
          disp_data_nxt[4*i +: 4] = (bus.edit_blink_mask[i] && blink_phase_nxt) ?
                                    BLANK_NIBBLE : bus.edit_data[4*i +: 4];
        end
      end
      ST_NOTIFY: disp_data_nxt = notify_lat_nxt;
      default:   disp_data_nxt = bus.bg_data;
    endcase
  end

  // State and output registers. An asynchronous reset aborts any notification without a done pulse.
  always_ff @(posedge clk_500hz or negedge rst) begin
    if (!rst) begin
      state         <= ST_BG;
      hold_cnt      <= '0;
      blink_cnt     <= '0;
      blink_phase_q <= 1'b0;
      notify_lat    <= '0;
      disp_data_q   <= '0;
      disp_src_q    <= 2'b00;
      notify_ack_q  <= 1'b0;
      notify_done_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      hold_cnt      <= hold_nxt;
      blink_cnt     <= blink_cnt_nxt;
      blink_phase_q <= blink_phase_nxt;
      notify_lat    <= notify_lat_nxt;
      disp_data_q   <= disp_data_nxt;
      disp_src_q    <= state_nxt;
      notify_ack_q  <= ack_nxt;
      notify_done_q <= done_nxt;
    end
  end

  assign bus.disp_data   = disp_data_q;
  assign bus.disp_src    = disp_src_q;
  assign bus.blink_phase = blink_phase_q;
  assign bus.notify_ack  = notify_ack_q;
  assign bus.notify_done = notify_done_q;

endmodule

// File: tb/tb_display_source_arbiter.sv
// Purpose: directed bench for display_source_arbiter, with hand-computed expectations.
// Latency: inputs are driven just after a falling edge and checked at the next falling edge, one rising edge later.
// Backpressure: not applicable; every wait is a fixed cycle count.
module tb_display_source_arbiter;
  localparam int BH = 125;
  localparam int NT = 1000;

  logic clk_500hz = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;

  display_source_arbiter_if bus();

  display_source_arbiter #(.BLINK_HALF(BH), .NOTIFY_TICKS(NT), .BLANK_NIBBLE(4'hF)) dut (
    .clk_500hz(clk_500hz),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk_500hz = ~clk_500hz;

  task automatic test_reset();
    bus.bg_data = 32'h12345678; bus.edit_active = 1'b0; bus.edit_data = 32'h0;
    bus.edit_blink_mask = 8'h00; bus.notify_req = 1'b0; bus.notify_data = 32'h0;
    @(negedge clk_500hz);
    checks++; if (bus.disp_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", bus.disp_data, 32'h0); end
    checks++; if (bus.disp_src !== 2'b00) begin errors++; $display("FAIL reset_src: got %b expected %b", bus.disp_src, 2'b00); end
    checks++; if ({bus.notify_ack, bus.notify_done, bus.blink_phase} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {bus.notify_ack, bus.notify_done, bus.blink_phase}); end
    rst = 1'b1;
    @(negedge clk_500hz);
    checks++; if (bus.disp_data !== 32'h12345678) begin errors++; $display("FAIL bg_pass: got %h expected %h", bus.disp_data, 32'h12345678); end
    checks++; if (bus.disp_src !== 2'b00) begin errors++; $display("FAIL bg_src: got %b expected %b", bus.disp_src, 2'b00); end
    rst = 1'b0;
    #1;
    checks++; if (bus.disp_data !== 32'h0) begin errors++; $display("FAIL midrun_reset: got %h expected %h", bus.disp_data, 32'h0); end
    @(negedge clk_500hz);
    rst = 1'b1;
    bus.bg_data = 32'h87654321;
    @(negedge clk_500hz);
    checks++; if (bus.disp_data !== 32'h87654321) begin errors++; $display("FAIL after_reset: got %h expected %h", bus.disp_data, 32'h87654321); end
  endtask

  task automatic test_edit_blink();
    bus.edit_active = 1'b1; bus.edit_data = 32'h00001230; bus.edit_blink_mask = 8'h03;
    @(negedge clk_500hz);
    checks++; if (bus.disp_src !== 2'b01) begin errors++; $display("FAIL edit_src: got %b expected %b", bus.disp_src, 2'b01); end
    checks++; if (bus.disp_data !== 32'h00001230) begin errors++; $display("FAIL edit_entry: got %h expected %h", bus.disp_data, 32'h00001230); end
    checks++; if (bus.blink_phase !== 1'b0) begin errors++; $display("FAIL edit_phase0: got %b expected 0", bus.blink_phase); end
    for (int k = 1; k < BH; k++) begin
      @(negedge clk_500hz);
      checks++; if (bus.disp_data !== 32'h00001230) begin errors++; $display("FAIL blink_on k=%0d: got %h expected %h", k, bus.disp_data, 32'h00001230); end
    end
    for (int k = BH; k < 2*BH; k++) begin
      @(negedge clk_500hz);
      checks++; if (bus.disp_data !== 32'h000012FF || bus.blink_phase !== 1'b1) begin errors++; $display("FAIL blink_off k=%0d: got %h/%b expected %h/1", k, bus.disp_data, bus.blink_phase, 32'h000012FF); end
    end
    @(negedge clk_500hz);
    checks++; if (bus.disp_data !== 32'h00001230 || bus.blink_phase !== 1'b0) begin errors++; $display("FAIL blink_wrap: got %h/%b expected %h/0", bus.disp_data, bus.blink_phase, 32'h00001230); end
    bus.edit_active = 1'b0;
    @(negedge clk_500hz);
    checks++; if (bus.disp_src !== 2'b00 || bus.disp_data !== 32'h87654321) begin errors++; $display("FAIL edit_exit: got %b/%h expected 00/%h", bus.disp_src, bus.disp_data, 32'h87654321); end
  endtask

  task automatic test_notify();
    bus.notify_req = 1'b1; bus.notify_data = 32'hAAAA5555;
    @(negedge clk_500hz);
    checks++; if (bus.notify_ack !== 1'b1 || bus.disp_src !== 2'b10) begin errors++; $display("FAIL notify_accept: got ack=%b src=%b expected ack=1 src=10", bus.notify_ack, bus.disp_src); end
    checks++; if (bus.disp_data !== 32'hAAAA5555) begin errors++; $display("FAIL notify_data: got %h expected %h", bus.disp_data, 32'hAAAA5555); end
    bus.notify_req = 1'b0;
    for (int k = 1; k < NT; k++) begin
      @(negedge clk_500hz);
      checks++; if (bus.disp_data !== 32'hAAAA5555 || bus.disp_src !== 2'b10 || bus.notify_ack !== 1'b0 || bus.notify_done !== 1'b0) begin
        errors++; $display("FAIL notify_hold k=%0d: got %h src=%b ack=%b done=%b expected %h src=10 ack=0 done=0", k, bus.disp_data, bus.disp_src, bus.notify_ack, bus.notify_done, 32'hAAAA5555);
      end
    end
    @(negedge clk_500hz);
    checks++; if (bus.notify_done !== 1'b1 || bus.disp_src !== 2'b00 || bus.disp_data !== 32'h87654321) begin errors++; $display("FAIL notify_expire: got done=%b src=%b %h expected done=1 src=00 %h", bus.notify_done, bus.disp_src, bus.disp_data, 32'h87654321); end
    @(negedge clk_500hz);
    checks++; if (bus.notify_done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", bus.notify_done); end
  endtask

  task automatic test_notify_edit();
    bus.notify_req = 1'b1; bus.notify_data = 32'h11112222;
    @(negedge clk_500hz);
    checks++; if (bus.disp_data !== 32'h11112222) begin errors++; $display("FAIL ne_accept: got %h expected %h", bus.disp_data, 32'h11112222); end
    bus.notify_req = 1'b0; bus.edit_active = 1'b1; bus.notify_data = 32'h99999999;
    for (int k = 1; k < NT; k++) begin
      @(negedge clk_500hz);
      checks++; if (bus.disp_data !== 32'h11112222 || bus.disp_src !== 2'b10) begin errors++; $display("FAIL ne_latched k=%0d: got %h src=%b expected %h src=10", k, bus.disp_data, bus.disp_src, 32'h11112222); end
    end
    @(negedge clk_500hz);
    checks++; if (bus.disp_src !== 2'b01 || bus.blink_phase !== 1'b0 || bus.notify_done !== 1'b1) begin errors++; $display("FAIL ne_to_edit: got src=%b phase=%b done=%b expected src=01 phase=0 done=1", bus.disp_src, bus.blink_phase, bus.notify_done); end
    checks++; if (bus.disp_data !== 32'h00001230) begin errors++; $display("FAIL ne_edit_data: got %h expected %h", bus.disp_data, 32'h00001230); end
    bus.edit_active = 1'b0;
    @(negedge clk_500hz);
    checks++; if (bus.disp_src !== 2'b00) begin errors++; $display("FAIL ne_exit: got %b expected 00", bus.disp_src); end
  endtask

  task automatic test_retrigger();
    bus.notify_req = 1'b1; bus.notify_data = 32'h0000BEEF;
    @(negedge clk_500hz);
    bus.notify_req = 1'b0;
    for (int k = 1; k < NT; k++) @(negedge clk_500hz);
    checks++; if (bus.disp_data !== 32'h0000BEEF) begin errors++; $display("FAIL rt_last: got %h expected %h", bus.disp_data, 32'h0000BEEF); end
    bus.notify_req = 1'b1; bus.notify_data = 32'h0000CAFE;
    @(negedge clk_500hz);
    checks++; if (bus.notify_ack !== 1'b1 || bus.notify_done !== 1'b0 || bus.disp_data !== 32'h0000CAFE) begin errors++; $display("FAIL rt_accept: got ack=%b done=%b %h expected ack=1 done=0 %h", bus.notify_ack, bus.notify_done, bus.disp_data, 32'h0000CAFE); end
    bus.notify_req = 1'b0;
    for (int k = 1; k < NT; k++) begin
      @(negedge clk_500hz);
      checks++; if (bus.disp_data !== 32'h0000CAFE || bus.notify_done !== 1'b0) begin errors++; $display("FAIL rt_hold k=%0d: got %h done=%b expected %h done=0", k, bus.disp_data, bus.notify_done, 32'h0000CAFE); end
    end
    @(negedge clk_500hz);
    checks++; if (bus.notify_done !== 1'b1 || bus.disp_src !== 2'b00) begin errors++; $display("FAIL rt_expire: got done=%b src=%b expected done=1 src=00", bus.notify_done, bus.disp_src); end
  endtask

  task automatic test_simultaneous();
    bus.notify_req = 1'b1; bus.edit_active = 1'b1; bus.notify_data = 32'h5A5A5A5A;
    @(negedge clk_500hz);
    checks++; if (bus.disp_src !== 2'b10 || bus.notify_ack !== 1'b1) begin errors++; $display("FAIL sim_notify: got src=%b ack=%b expected src=10 ack=1", bus.disp_src, bus.notify_ack); end
    bus.notify_req = 1'b0;
    for (int k = 1; k < NT; k++) begin
      @(negedge clk_500hz);
      checks++; if (bus.disp_src !== 2'b10) begin errors++; $display("FAIL sim_hold k=%0d: got src=%b expected 10", k, bus.disp_src); end
    end
    @(negedge clk_500hz);
    checks++; if (bus.disp_src !== 2'b01 || bus.notify_done !== 1'b1) begin errors++; $display("FAIL sim_edit: got src=%b done=%b expected src=01 done=1", bus.disp_src, bus.notify_done); end
    bus.edit_active = 1'b0;
    @(negedge clk_500hz);
    checks++; if (bus.disp_src !== 2'b00 || bus.disp_data !== 32'h87654321) begin errors++; $display("FAIL sim_bg: got src=%b %h expected src=00 %h", bus.disp_src, bus.disp_data, 32'h87654321); end
  endtask

  initial begin
    test_reset();
    test_edit_blink();
    test_notify();
    test_notify_edit();
    test_retrigger();
    test_simultaneous();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
